// File: rtl/tinyalu_pkg.sv
// Shared types, widths and the reference model for the TinyALU checker.
package tinyalu_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    typedef enum logic [OP_W-1:0] {
        NO_OP = 3'b000,
        ADD   = 3'b001,
        AND   = 3'b010,
        XOR   = 3'b011,
        MUL   = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_NOOP,
        S_HALT
    } state_e;

    function automatic logic [RES_W-1:0] predict(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [RES_W-1:0] r;
        r = '0;
        case (op)
            ADD:     r = {8'h00, a} + {8'h00, b};
            AND:     r = {8'h00, a & b};
            XOR:     r = {8'h00, a ^ b};
            MUL:     r = RES_W'(a) * RES_W'(b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Codes 101-111 behave exactly like NO_OP.
    function automatic logic is_noop(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b1;
        case (op)
            ADD, AND, XOR, MUL: r = 1'b0;
            default:            r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_predictor.sv
// Combinational expected-result generator for one TinyALU operation.
module tinyalu_predictor
    import tinyalu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [RES_W-1:0]  o_expected
);

    assign o_expected = predict(i_op, i_a, i_b);

endmodule

// File: rtl/tinyalu_scoreboard.sv
// Drives the TinyALU start/done handshake, checks each result against
// the prediction and keeps saturating pass/fail statistics.
module tinyalu_scoreboard
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int MAX_FAILS = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              alu_reset_n,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    output logic              cmp_valid,
    output logic              cmp_pass,
    output logic [RES_W-1:0]  cmp_expected,
    output logic [RES_W-1:0]  cmp_actual,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              timeout_err,
    output logic              halt
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic [RES_W-1:0] r_pred;
    logic [RES_W-1:0] w_pred;
    logic             w_accept;
    logic             w_done;
    logic             w_tmo;
    logic             w_cmp;
    logic             w_pass;
    logic             w_thresh;
    logic [CNT_W-1:0] w_fail_inc;
    logic [CNT_W-1:0] w_pass_inc;

    tinyalu_predictor u_pred (
        .i_op       (in_op),
        .i_a        (in_a),
        .i_b        (in_b),
        .o_expected (w_pred)
    );

    assign in_ready   = (r_state == S_IDLE) & ~reset;
    assign w_accept   = in_ready & in_valid;
    assign w_done     = (r_state == S_DRIVE) & alu_done;
    assign w_tmo      = (r_state == S_DRIVE) & ~alu_done
                      & (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_cmp      = w_done | w_tmo;
    assign w_pass     = w_done & (alu_result == r_pred);
    assign w_fail_inc = (&fail_count) ? fail_count : fail_count + 1'b1;
    assign w_pass_inc = (&pass_count) ? pass_count : pass_count + 1'b1;
    // Counters lag the compare by one edge, so look ahead for the halt decision.
    assign w_thresh   = w_cmp & ~w_pass
                      & (w_fail_inc >= CNT_W'(MAX_FAILS));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_accept)
                    w_state_nxt = is_noop(in_op) ? S_NOOP : S_DRIVE;
            S_NOOP:
                w_state_nxt = S_IDLE;
            S_DRIVE:
                if (w_cmp)
                    w_state_nxt = w_thresh ? S_HALT : S_IDLE;
            S_HALT:
                w_state_nxt = S_HALT;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_pred       <= '0;
            alu_reset_n  <= 1'b0;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            cmp_valid    <= 1'b0;
            cmp_pass     <= 1'b0;
            cmp_expected <= '0;
            cmp_actual   <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
            timeout_err  <= 1'b0;
            halt         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            alu_reset_n <= 1'b1;
            cmp_valid   <= w_cmp;

            if (w_accept) begin
                alu_start <= 1'b1;
                alu_op    <= in_op;
                alu_a     <= in_a;
                alu_b     <= in_b;
                r_pred    <= w_pred;
                r_tmo     <= '0;
            end else if (r_state == S_NOOP || w_cmp) begin
                alu_start <= 1'b0;
                alu_op    <= '0;
                alu_a     <= '0;
                alu_b     <= '0;
            end else if (r_state == S_DRIVE) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_cmp) begin
                cmp_pass     <= w_pass;
                cmp_expected <= r_pred;
                cmp_actual   <= w_done ? alu_result : '0;
            end

            if (w_tmo)
                timeout_err <= 1'b1;

            if (cmp_valid) begin
                if (cmp_pass) begin
                    pass_count <= w_pass_inc;
                end else begin
                    fail_count <= w_fail_inc;
                    if (w_fail_inc >= CNT_W'(MAX_FAILS))
                        halt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tinyalu_scoreboard.sv
// Table-driven bench for tinyalu_scoreboard: the bench plays the ALU and
// checks every comparison pulse against a queue of expected records.
module tb_tinyalu_scoreboard;
    import tinyalu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        alu_reset_n;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        cmp_valid;
    logic        cmp_pass;
    logic [15:0] cmp_expected;
    logic [15:0] cmp_actual;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic        timeout_err;
    logic        halt;

    tinyalu_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_reset_n  (alu_reset_n),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .cmp_valid    (cmp_valid),
        .cmp_pass     (cmp_pass),
        .cmp_expected (cmp_expected),
        .cmp_actual   (cmp_actual),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .timeout_err  (timeout_err),
        .halt         (halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] ret;
        logic [15:0] exp;
        logic        pass;
        logic        noop;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] act;
        logic        pass;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_pass   = 0;
    int   m_fail   = 0;
    bit   chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every cmp_valid pulse must match the oldest pushed record.
    always @(negedge clk) begin
        if (chk_cnt) begin
            chk_cnt = 0;
            check("pass_count", 32'(pass_count), 32'(m_pass));
            check("fail_count", 32'(fail_count), 32'(m_fail));
        end
        if (cmp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_cmp: got cmp_valid=1 expected 0");
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("cmp_expected", 32'(cmp_expected), 32'(e.exp));
                check("cmp_actual", 32'(cmp_actual), 32'(e.act));
                check("cmp_pass", 32'(cmp_pass), 32'(e.pass));
                if (e.pass) m_pass++;
                else m_fail++;
                chk_cnt = 1;
            end
        end
    end

    task automatic check_reset_vals(input logic exp_ready);
        check("rst_in_ready", 32'(in_ready), 32'(exp_ready));
        check("rst_alu_reset_n", 32'(alu_reset_n), 0);
        check("rst_alu_start", 32'(alu_start), 0);
        check("rst_alu_opab", {8'h0, alu_op, 5'h0, alu_a, alu_b}, 0);
        check("rst_cmp", {15'h0, cmp_valid, cmp_pass}, 0);
        check("rst_cmp_data", {cmp_expected, cmp_actual}, 0);
        check("rst_counts", {pass_count, fail_count}, 0);
        check("rst_flags", {30'h0, timeout_err, halt}, 0);
    endtask

    // Called at a negedge; returns at a negedge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        alu_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_vals(1'b0);
        sb.delete();
        m_pass = 0;
        m_fail = 0;
        chk_cnt = 0;
        reset = 1'b0;
        #1;
        check_reset_vals(1'b1);
        @(negedge clk);
        check("alu_reset_n_rise", 32'(alu_reset_n), 1);
    endtask

    // Starts and ends at a negedge; ends in the cycle after done (or noop).
    task automatic do_op(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int lat,
                         input logic [15:0] ret, input logic [15:0] exp,
                         input logic pass, input logic noop,
                         input logic exp_ready);
        sb_t e;
        check("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        check("start_rise", 32'(alu_start), 1);
        check("drive_opab", {8'h0, alu_op, 5'h0, alu_a, alu_b},
              {8'h0, op, 5'h0, a, b});
        if (noop) begin
            @(negedge clk);
            check("noop_start_fall", 32'(alu_start), 0);
            check("noop_ready", 32'(in_ready), 1);
            return;
        end
        e.exp = exp;
        e.act = ret;
        e.pass = pass;
        sb.push_back(e);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("start_held", 32'(alu_start), 1);
        end
        alu_done = 1'b1;
        alu_result = ret;
        @(negedge clk);
        alu_done = 1'b0;
        alu_result = 16'hDEAD;
        check("start_fall", 32'(alu_start), 0);
        check("idle_opab", {8'h0, alu_op, 5'h0, alu_a, alu_b}, 0);
        check("ready_after_done", 32'(in_ready), 32'(exp_ready));
    endtask

    initial begin
        int cnt;
        vecs[0] = '{ADD,  8'hFF, 8'h01, 1, 16'h0100, 16'h0100, 1'b1, 1'b0};
        vecs[1] = '{MUL,  8'hFF, 8'hFF, 3, 16'hFE01, 16'hFE01, 1'b1, 1'b0};
        vecs[2] = '{AND,  8'hF0, 8'h3C, 2, 16'h0030, 16'h0030, 1'b1, 1'b0};
        vecs[3] = '{XOR,  8'hF0, 8'h3C, 1, 16'h00CC, 16'h00CC, 1'b1, 1'b0};
        vecs[4] = '{NO_OP, 8'h12, 8'h34, 0, 16'h0, 16'h0, 1'b0, 1'b1};
        vecs[5] = '{3'b111, 8'h56, 8'h78, 0, 16'h0, 16'h0, 1'b0, 1'b1};
        vecs[6] = '{MUL,  8'h0C, 8'h0D, 2, 16'h009C, 16'h009C, 1'b1, 1'b0};
        vecs[7] = '{ADD,  8'h80, 8'h80, 4, 16'h0100, 16'h0100, 1'b1, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        alu_done = 1'b0;
        alu_result = '0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
                  vecs[i].ret, vecs[i].exp, vecs[i].pass, vecs[i].noop,
                  1'b1);
        @(negedge clk);
        @(negedge clk);
        check("table_passes", 32'(pass_count), 6);

        // Spurious done while idle is ignored.
        alu_done = 1'b1;
        alu_result = 16'h1234;
        @(negedge clk);
        alu_done = 1'b0;
        check("spurious_start", 32'(alu_start), 0);
        @(negedge clk);
        @(negedge clk);
        check("spurious_counts", {pass_count, fail_count}, {16'd6, 16'd0});

        // Two mismatches reach the halt threshold.
        do_op(ADD, 8'h01, 8'h01, 1, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b1);
        do_op(ADD, 8'h01, 8'h01, 2, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("halt_set", 32'(halt), 1);
        check("halt_fails", 32'(fail_count), 2);
        in_valid = 1'b1;
        in_op = ADD;
        alu_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halt_ready", 32'(in_ready), 0);
            check("halt_start", 32'(alu_start), 0);
        end
        in_valid = 1'b0;
        alu_done = 1'b0;
        do_reset();

        // Reset in the middle of an operation abandons it.
        in_valid = 1'b1;
        in_op = MUL;
        in_a = 8'h03;
        in_b = 8'h04;
        @(negedge clk);
        in_valid = 1'b0;
        check("midop_start", 32'(alu_start), 1);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("midop_counts", {pass_count, fail_count}, 0);

        // Timeout: done never arrives.
        check("tmo_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_op = ADD;
        in_a = 8'h02;
        in_b = 8'h03;
        sb.push_back('{16'h0005, 16'h0000, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (alu_start === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_start_cycles", 32'(cnt), 64);
        check("tmo_err", 32'(timeout_err), 1);
        check("tmo_ready_back", 32'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        check("tmo_fail_count", 32'(fail_count), 1);
        check("tmo_no_halt", 32'(halt), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
